// File: rtl/rr_queue_arbiter_pkg.sv
// Shared helpers for the round-robin queue arbiter: source-tag width and entry packing.
package rr_queue_arbiter_pkg;

    // Tag width for n requesters; never narrower than one bit.
    function automatic int src_nbits(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int entry_nbits(input int src_w, input int msg_w);
        return src_w + msg_w;
    endfunction

endpackage

// File: rtl/rr_arb_core.sv
// Combinational round-robin priority search starting at ptr, wrapping modulo NUM_REQS.
module rr_arb_core #(
    parameter int NUM_REQS = 4,
    parameter int SRC_W    = 2
) (
    input  logic [NUM_REQS-1:0] req_val,
    input  logic [SRC_W-1:0]    ptr,
    input  logic                en,
    output logic [NUM_REQS-1:0] grant,
    output logic [SRC_W-1:0]    idx
);

    int   cand;
    logic found;

    always_comb begin
        grant = '0;
        idx   = '0;
        cand  = 0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQS; k++) begin
            // Explicit wrap so non-power-of-two requester counts work.
            cand = int'(ptr) + k;
            if (cand >= NUM_REQS) cand = cand - NUM_REQS;
            if (!found && en && req_val[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = SRC_W'(cand);
            end
        end
    end

endmodule

// File: rtl/rr_queue_arbiter.sv
// Round-robin arbiter feeding a two-entry normal queue; tags each message with its source.
module rr_queue_arbiter
    import rr_queue_arbiter_pkg::*;
#(
    parameter int  p_num_reqs  = 4,
    parameter int  p_msg_nbits = 32,
    localparam int c_src_nbits = src_nbits(p_num_reqs)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [p_num_reqs-1:0]             req_val,
    output logic [p_num_reqs-1:0]             req_rdy,
    input  logic [p_num_reqs*p_msg_nbits-1:0] req_msg,
    output logic                              deq_val,
    input  logic                              deq_rdy,
    output logic [p_msg_nbits-1:0]            deq_msg,
    output logic [c_src_nbits-1:0]            deq_src
);

    typedef struct packed {
        logic [c_src_nbits-1:0] src;
        logic [p_msg_nbits-1:0] msg;
    } entry_t;

    entry_t                  q [2];
    logic [1:0]              full;
    logic                    head;
    logic [c_src_nbits-1:0]  ptr;

    logic                    enq_rdy;
    logic                    enq;
    logic                    deq;
    logic                    tail;
    logic [p_num_reqs-1:0]   grant;
    logic [c_src_nbits-1:0]  grant_idx;
    logic [p_msg_nbits-1:0]  msg_sel;

    assign enq_rdy = ~full[0] | ~full[1];

    // Gating the search with reset keeps req_rdy low while reset is held.
    rr_arb_core #(
        .NUM_REQS (p_num_reqs),
        .SRC_W    (c_src_nbits)
    ) u_arb (
        .req_val (req_val),
        .ptr     (ptr),
        .en      (enq_rdy & reset),
        .grant   (grant),
        .idx     (grant_idx)
    );

    assign req_rdy = grant;
    assign enq     = |grant;
    assign msg_sel = req_msg[int'(grant_idx)*p_msg_nbits +: p_msg_nbits];

    assign deq_val = full[head];
    assign deq     = deq_val & deq_rdy;
    assign deq_msg = q[head].msg;
    assign deq_src = q[head].src;

    // With one entry it always sits at head, so the free slot is the other one.
    assign tail = full[head] ? ~head : head;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr  <= '0;
            full <= '0;
            head <= 1'b0;
            q[0] <= '0;
            q[1] <= '0;
        end else begin
            if (enq) begin
                q[tail]    <= '{src: grant_idx, msg: msg_sel};
                full[tail] <= 1'b1;
                ptr        <= (grant_idx == c_src_nbits'(p_num_reqs-1)) ? '0 : grant_idx + 1'b1;
            end
            if (deq) begin
                full[head] <= 1'b0;
                head       <= ~head;
            end
        end
    end

endmodule

// File: tb/tb_rr_queue_arbiter.sv
// Randomized scoreboard bench for rr_queue_arbiter against a queue-based reference model.
module tb_rr_queue_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int SW = 2;

    logic           clk     = 1'b0;
    logic           reset   = 1'b0;
    logic [N-1:0]   req_val = '0;
    logic [N-1:0]   req_rdy;
    logic [N*W-1:0] req_msg = '0;
    logic           deq_val;
    logic           deq_rdy = 1'b0;
    logic [W-1:0]   deq_msg;
    logic [SW-1:0]  deq_src;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int           src;
        logic [W-1:0] msg;
    } ent_t;

    ent_t         sb[$];
    int           m_ptr = 0;
    int           m_occ = 0;
    bit           p_enq = 0;
    bit           p_deq = 0;
    int           p_src = 0;
    logic [W-1:0] p_msg = '0;

    always #5 clk = ~clk;

    rr_queue_arbiter #(.p_num_reqs(N), .p_msg_nbits(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .req_val (req_val),
        .req_rdy (req_rdy),
        .req_msg (req_msg),
        .deq_val (deq_val),
        .deq_rdy (deq_rdy),
        .deq_msg (deq_msg),
        .deq_src (deq_src)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: round-robin search from m_ptr, grant only while fewer than 2 held.
    always @(negedge clk) begin : model_chk
        logic [N-1:0] exp_rdy;
        int           ci;
        bit           found;
        exp_rdy = '0;
        found   = 0;
        p_enq   = 0;
        p_deq   = 0;
        if (reset && m_occ < 2) begin
            for (int k = 0; k < N; k++) begin
                ci = (m_ptr + k) % N;
                if (!found && req_val[ci]) begin
                    found       = 1;
                    exp_rdy[ci] = 1'b1;
                    p_enq       = 1;
                    p_src       = ci;
                    p_msg       = req_msg[ci*W +: W];
                end
            end
        end
        chk("req_rdy", req_rdy, exp_rdy);
        p_deq = reset && (m_occ > 0) && deq_rdy;
    end

    always @(posedge clk) begin
        if (!reset) begin
            sb.delete();
            m_occ = 0;
            m_ptr = 0;
        end else begin
            if (p_enq) begin
                sb.push_back('{p_src, p_msg});
                m_ptr = (p_src + 1) % N;
            end
            m_occ = m_occ + int'(p_enq) - int'(p_deq);
        end
        p_enq = 0;
        p_deq = 0;
    end

    // Monitor: pops the scoreboard whenever the DUT hands over an entry.
    always @(negedge clk) begin : monitor
        ent_t e;
        chk("deq_val", deq_val, (reset && m_occ > 0));
        if (reset && deq_val && deq_rdy) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL deq_underflow: got dequeue expected none at %0t", $time);
            end else begin
                e = sb.pop_front();
                chk("deq_src", deq_src, e.src);
                chk("deq_msg", deq_msg, e.msg);
            end
        end
    end

    task automatic drive(input logic [N-1:0] v, input logic dr);
        req_val = v;
        deq_rdy = dr;
        for (int i = 0; i < N; i++) req_msg[i*W +: W] = $urandom;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_val = '0;
        deq_rdy = 1'b0;
        reset   = 1'b0;
        @(posedge clk);
        #1;
        reset   = 1'b1;
    endtask

    initial begin
        // Reset state, with requests pending to show req_rdy is forced low.
        req_val = 4'b1111;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_rdy", req_rdy, 4'b0000);
        chk("rst_deq_val", deq_val, 1'b0);
        chk("rst_deq_msg", deq_msg, 32'h0);
        chk("rst_deq_src", deq_src, 2'd0);

        // Single request from requester 2.
        reset   = 1'b1;
        req_val = 4'b0100;
        deq_rdy = 1'b0;
        req_msg = '0;
        req_msg[2*W +: W] = 32'hA5;
        #1;
        chk("t1_req_rdy", req_rdy, 4'b0100);
        @(posedge clk);
        #1;
        chk("t1_deq_val", deq_val, 1'b1);
        chk("t1_deq_msg", deq_msg, 32'hA5);
        chk("t1_deq_src", deq_src, 2'd2);
        drive(4'b0000, 1'b1);
        drive(4'b0000, 1'b1);

        // Full contention with free-running consumer.
        do_reset();
        for (int c = 0; c < 10; c++) drive(4'b1111, 1'b1);

        // Sparse wrap between requesters 3 and 0.
        do_reset();
        drive(4'b0001, 1'b1);
        for (int c = 0; c < 6; c++) drive(4'b1001, 1'b1);

        // Backpressure, single-cycle drain, then refill.
        do_reset();
        for (int c = 0; c < 4; c++) drive(4'b1111, 1'b0);
        drive(4'b1111, 1'b1);
        for (int c = 0; c < 3; c++) drive(4'b1111, 1'b0);

        // Asynchronous reset with both entries full.
        chk("pre_arst_deq_val", deq_val, 1'b1);
        req_val = 4'b1111;
        #2;
        reset = 1'b0;
        #1;
        chk("arst_deq_val", deq_val, 1'b0);
        chk("arst_req_rdy", req_rdy, 4'b0000);
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int c = 0; c < 4; c++) drive(4'b1111, 1'b0);

        // Random traffic with varying consumer readiness.
        for (int blk = 0; blk < 6; blk++) begin
            int bias;
            bias = blk % 3;
            for (int c = 0; c < 500; c++)
                drive(N'($urandom), ($urandom_range(0, 3) > bias) ? 1'b1 : 1'b0);
        end

        for (int c = 0; c < 4; c++) drive(4'b0000, 1'b1);
        chk("drain_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rr_queue_arbiter.md
# rr_queue_arbiter

Round-robin arbiter that shares one two-entry output queue between `p_num_reqs` val/rdy requesters. It accepts at most one message per cycle from the highest-priority valid requester and tags the message with its source index. It buffers the tagged message in a two-entry normal (non-bypass) queue and presents it on a single val/rdy dequeue port. It sits in front of any shared downstream consumer (e.g. a single response or egress channel) that several producers in the design must time-share fairly.

## Interface
- `p_num_reqs`, default 4: number of requesters; legal range 2..16.
- `p_msg_nbits`, default 32: payload width per requester.
- `c_src_nbits` (localparam) = `$clog2(p_num_reqs)`: source-tag width.
- `clk`  input  1  sole clock; all state updates on rising edge.
- `reset`  input  1  reset, asynchronous and active-low (asserted when 0).
- `req_val`  input  p_num_reqs  per-requester valid.
- `req_rdy`  output  p_num_reqs  per-requester ready; one-hot or zero.
- `req_msg`  input  p_num_reqs*p_msg_nbits  packed payloads; requester i occupies bits [i*p_msg_nbits +: p_msg_nbits].
- `deq_val`  output  1  output queue holds at least one entry.
- `deq_rdy`  input  1  consumer accepts head entry.
- `deq_msg`  output  p_msg_nbits  head-entry payload.
- `deq_src`  output  c_src_nbits  head-entry source index.

## Operation
- State: priority pointer `ptr` (c_src_nbits), two queue entries each {src, msg}, per-entry full bits, head pointer.
- Grant: when `enq_rdy` (queue not full) is high, grant the first i with `req_val[i]=1`, searching `ptr`, `ptr+1`, … modulo `p_num_reqs`.
- `req_rdy[i] = grant[i] & enq_rdy`. It is combinationally dependent on `req_val`. Requesters must not make `req_val` depend on `req_rdy`.
- Transfer on requester i occurs when `req_val[i] & req_rdy[i]`. The entry {i, req_msg slice i} is written to the queue tail.
- Pointer update: on a transfer from i, `ptr <= (i == p_num_reqs-1) ? 0 : i+1`. With no transfer, `ptr` holds. Wrap is explicit and must not rely on power-of-two `p_num_reqs`.
- Queue: two entries. `enq_rdy = ~full[0] | ~full[1]`. `deq_val = full[head]`. A dequeue occurs on `deq_val & deq_rdy`, which clears `full[head]` and toggles `head`.
- Full queue: `enq_rdy=0`, so all `req_rdy=0`, even if a dequeue happens in the same cycle. There is no bypass and no pass-through.
- Simultaneous enqueue and dequeue with one entry occupied: both happen, and occupancy stays at 1.
- Empty queue: `deq_val=0`, and `deq_msg`/`deq_src` are don't-care.
- Held requests: a requester whose `req_val` stays high while not granted keeps its payload stable. The arbiter gives no starvation guarantee beyond round-robin, which bounds the wait to `p_num_reqs-1` grants.
- Reset asserted (reset=0), including mid-operation: `ptr=0`, both full bits 0, `head=0`. In-flight entries are discarded. `req_rdy` is forced to all zeros while reset is asserted.

## Timing
- Reset values: `req_rdy=0`, `deq_val=0`, `deq_msg=0`, `deq_src=0`.
- Latency: a message accepted in cycle t is visible on `deq_*` in cycle t+1 at the earliest.
- Throughput: 1 message/cycle sustained with `deq_rdy=1`. Occupancy then oscillates between 1 and 2, or stays at 1.
- Critical path: `req_val` → priority search → `req_rdy` and the queue write enable. This is one combinational level of `p_num_reqs` width.
- The first cycle after reset deasserts, the block may accept a request.

## Structure
- Shared package `rr_queue_arbiter_pkg`: the `c_src_nbits` computation function and an entry struct typedef {src, msg} parameterised by widths. Where struct parameterisation is not available, use localparam offsets instead.
- One sub-module, `rr_arb_core`: combinational round-robin priority search (inputs `req_val`, `ptr`, `en`; output one-hot `grant` and encoded index). The pointer register stays in the top.
- The queue storage is inline in the top level; no separate queue instance.

## Test plan
- Reset, then `req_val=4'b0100` with msg 0xA5: `req_rdy=4'b0100` the same cycle; next cycle `deq_val=1`, `deq_msg=0xA5`, `deq_src=2`; `ptr=3`.
- All `req_val=4'b1111`, `deq_rdy=1` for 8 cycles: `deq_src` sequence is 0,1,2,3,0,1,2,3; one output per cycle after a 1-cycle fill.
- Sparse wrap with `ptr=1` and `req_val=4'b1001`: grant 3, then `ptr=0`, then grant 0, then `ptr=1`.
- Backpressure with `deq_rdy=0` and `req_val=4'b1111`: two accepts (src 0, 1), then `req_rdy=0`. Raise `deq_rdy` for 1 cycle: one dequeue (src 0), and still no accept that cycle. An accept of src 2 follows on the next cycle.
- One entry queued, with `deq_rdy=1` and `req_val[1]=1` in the same cycle: dequeue and enqueue both occur, and `deq_val` stays 1 with the new entry.
- Assert reset asynchronously mid-cycle with 2 entries full: `deq_val` and `req_rdy` drop to 0 immediately without a clock edge; after release, `ptr=0` and the queue is empty.
